// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select, imem request handshake and IF/ID register.
// Optional IF_PERF_CNT_EN adds perf_fetched / perf_bubbles counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  PC_src,
    input  logic        pc_write,
    input  logic        IF_ID_write,
    input  logic        IF_ID_flush,
    input  logic [31:0] PFC_to_IF,
    input  logic [31:0] PFC_to_EX,
    input  logic [31:0] jr_target,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        IF_ID_valid,
    output logic        fetch_busy
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`endif
);

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_DROP = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    logic [1:0]  state, state_n;
    logic [31:0] pc_reg, pc_reg_n;
    logic [31:0] pend_pc, pend_pc_n;
    logic [31:0] buf_pc, buf_pc_n;
    logic [31:0] buf_inst, buf_inst_n;
    logic [31:0] target;
    logic        redirect, complete, hold_dlv, fetch_dlv, dlv;

    always_comb begin
        target = PFC_to_IF;
        case (PC_src)
            3'd1:    target = PFC_to_IF;
            3'd2:    target = PFC_to_EX;
            3'd3:    target = jr_target;
            default: target = PFC_to_IF;
        endcase
    end

    assign redirect   = pc_write & ((PC_src == 3'd1) | (PC_src == 3'd2) | (PC_src == 3'd3));
    // DROP reissues the old pc_reg (pending target parked elsewhere), so addr is always pc_reg
    assign imem_addr  = pc_reg;
    assign imem_req   = rst & (state != S_HOLD);
    assign complete   = imem_req & imem_valid;
    assign fetch_busy = ~(complete & (state == S_REQ));

    assign hold_dlv  = (state == S_HOLD) & ~redirect;
    assign fetch_dlv = (state == S_REQ) & complete & ~redirect & pc_write;
    assign dlv       = hold_dlv | fetch_dlv;

    always_comb begin
        state_n    = state;
        pc_reg_n   = pc_reg;
        pend_pc_n  = pend_pc;
        buf_pc_n   = buf_pc;
        buf_inst_n = buf_inst;
        case (state)
            S_REQ: begin
                if (redirect) begin
                    if (complete) begin
                        pc_reg_n = target;
                    end else begin
                        pend_pc_n = target;
                        state_n   = S_DROP;
                    end
                end else if (complete && !IF_ID_flush) begin
                    if (pc_write) pc_reg_n = pc_reg + 32'd1;
                    // Decode cannot take the word this edge: park it
                    if (!pc_write || !IF_ID_write) begin
                        buf_pc_n   = pc_reg;
                        buf_inst_n = imem_rdata;
                        state_n    = S_HOLD;
                    end
                end
            end
            S_DROP: begin
                if (redirect) begin
                    if (complete) begin
                        pc_reg_n = target;
                        state_n  = S_REQ;
                    end else begin
                        pend_pc_n = target;
                    end
                end else if (complete) begin
                    pc_reg_n = pend_pc;
                    state_n  = S_REQ;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    pc_reg_n = target;
                    state_n  = S_REQ;
                end else if (IF_ID_flush) begin
                    state_n = S_REQ;
                end else if (IF_ID_write) begin
                    if (pc_write) pc_reg_n = buf_pc + 32'd1;
                    state_n = S_REQ;
                end
            end
            default: state_n = S_REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_REQ;
            pc_reg   <= RESET_PC;
            pend_pc  <= RESET_PC;
            buf_pc   <= 32'd0;
            buf_inst <= NOP_INST;
        end else begin
            state    <= state_n;
            pc_reg   <= pc_reg_n;
            pend_pc  <= pend_pc_n;
            buf_pc   <= buf_pc_n;
            buf_inst <= buf_inst_n;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= 32'd0;
            inst        <= NOP_INST;
            IF_ID_valid <= 1'b0;
        end else if (IF_ID_flush) begin
            pc          <= 32'd0;
            inst        <= NOP_INST;
            IF_ID_valid <= 1'b0;
        end else if (IF_ID_write) begin
            if (hold_dlv) begin
                pc          <= buf_pc;
                inst        <= buf_inst;
                IF_ID_valid <= 1'b1;
            end else if (fetch_dlv) begin
                pc          <= pc_reg;
                inst        <= imem_rdata;
                IF_ID_valid <= 1'b1;
            end else begin
                pc          <= pc_reg;
                inst        <= NOP_INST;
                IF_ID_valid <= 1'b0;
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetched <= 32'd0;
            perf_bubbles <= 32'd0;
        end else begin
            if (!IF_ID_flush && IF_ID_write && dlv) perf_fetched <= perf_fetched + 32'd1;
            if (IF_ID_flush || (IF_ID_write && !dlv)) perf_bubbles <= perf_bubbles + 32'd1;
        end
    end
`endif

endmodule
